mgr_noc_mwc_arb: RTL and testbench
==================================

// Module: mgr_noc_mwc_arb
// PURPOSE
//  Packet-atomic arbiter that merges the NoC control-path (cp) and data-path (dp) packet streams into the
//  single MWC input port of the manager. It sits between the NoC controller and the MWC, replacing the
//  direct dp pass-through with buffered, fair, round-robin sharing.
//  Each input has a small FIFO, so the registered (one-cycle-late) ready used on the NoC side never drops beats.
// PARAMETERS
//  FIFO_DEPTH   4    entries per input FIFO; power of two, >= 4
//  CNT_W        16   width of the per-source packet-forwarded counters
// PORTS
//  clk                   in   1                 clock; all logic is rising edge
//  reset_poweron         in   1                 asynchronous reset, active-high
//  noc__arb__cp_valid    in   1                 cp beat valid
//  noc__arb__cp_cntl     in   CNTL_W            cp framing: SOM/MOM/EOM/SOM_EOM
//  noc__arb__cp_type     in   TYPE_W            cp packet type
//  noc__arb__cp_ptype    in   PTYPE_W           cp payload type
//  noc__arb__cp_data     in   DATA_W            cp payload
//  noc__arb__cp_pvalid   in   1                 cp payload valid
//  noc__arb__cp_mgrId    in   MGRID_W           cp source manager id
//  arb__noc__cp_ready    out  1                 cp may send (registered)
//  noc__arb__dp_*        in   (as cp)           dp beat; fields identical to cp
//  arb__noc__dp_ready    out  1                 dp may send (registered)
//  arb__mwc__valid/cntl/type/ptype/data/pvalid/mgrId  out  (as cp)  merged beat to MWC (registered)
//  mwc__arb__ready       in   1                 MWC accepts the beat this cycle
//  arb__sts__cp_pkts     out  CNT_W             cp packets forwarded (EOM beats transferred)
//  arb__sts__dp_pkts     out  CNT_W             dp packets forwarded
//  arb__sts__busy        out  1                 a packet is in flight (state LOCK)
// BEHAVIOUR
//  Reset: all outputs 0, FIFOs empty, state IDLE, last-grant = dp (so cp wins the first tie).
//  Input side: a beat is written whenever *_valid=1; the source obeys ready with 1 cycle of lag.
//   *_ready <= (count <= FIFO_DEPTH-3); this leaves 2 entries of slack for in-flight beats.
//   A write to a full FIFO is a protocol error: the beat is dropped and a sim-only $error is raised.
//  Output stage: a single register. A beat transfers when arb__mwc__valid && mwc__arb__ready.
//   The stage reloads in the same cycle it transfers, so it sustains 1 beat/clk.
//   Data is held stable while valid=1 and ready=0.
//  FSM IDLE/LOCK:
//   IDLE: a source is eligible when its FIFO head is non-empty and carries SOM or SOM_EOM.
//    Both eligible -> grant the source that was not last granted; one eligible -> grant it.
//    On grant, pop the head into the output stage. SOM_EOM stays in IDLE; SOM goes to LOCK.
//   LOCK: pop only the granted FIFO whenever the output stage is free or transferring.
//    Return to IDLE when the EOM beat is loaded into the output stage.
//    No interleaving: an empty granted FIFO mid-packet causes a bubble, not a switch.
//  Framing errors:
//   A head carrying MOM/EOM while IDLE is discarded; sim-only $error.
//   A SOM seen while LOCK is forwarded as-is (the MWC handles it); the lock is not broken.
//  Latency: input beat to arb__mwc__valid is 2 clk when FIFO is empty, output is free, and the source is granted.
//  Counters: increment when an EOM or SOM_EOM beat of that source transfers to the MWC. Wrap at 2^CNT_W-1 -> 0.
//  Simultaneous: a FIFO write and pop in the same cycle leaves count unchanged. A write to an empty FIFO is not poppable until the next cycle.
//  arb__sts__busy = (state==LOCK).
// STRUCTURE
//  Shared package/header mgr_noc_cntl.vh holds field widths (CNTL_W, TYPE_W, PTYPE_W, DATA_W, MGRID_W).
//   It also holds the framing encodings: SOM=2'b01, MOM=2'b00, EOM=2'b10, SOM_EOM=2'b11.
//  Sub-module mgr_pkt_fifo: one instance per input.
//   Synchronous write/read, count output, beat = {cntl,type,ptype,data,pvalid,mgrId}.
//  Top level: 2 FIFOs, arbitration FSM, output register, counters.
// TESTING
//  1 cp packet SOM,MOM,EOM (data 0x11,0x22,0x33), ready=1 -> 3 MWC beats in order, first at +2 clk; cp_pkts=1.
//  2 cp and dp each send a 4-beat packet in the same cycle after reset -> all cp beats, then all dp beats, no interleave.
//  3 Alternating 1-beat SOM_EOM packets on both inputs continuously -> MWC sees cp,dp,cp,dp...
//     At 1 beat/clk each count rises by 1 every 2 clk.
//  4 mwc ready=0 for 10 clk while dp streams -> dp_ready falls once count>1.
//     No beat is lost or duplicated; output data is stable while stalled.
//  5 dp sends an EOM with no SOM while IDLE -> the beat is discarded and $error fires.
//     The next SOM_EOM is forwarded normally.
//  6 reset asserted mid-packet (after 2 of 5 beats) -> outputs 0 asynchronously, FIFOs empty.
//     After release the next cp packet is granted first.

Source files
------------

// File: rtl/mgr_noc_mwc_arb_pkg.sv
// ============================================================================
// Module   : mgr_noc_mwc_arb_pkg
// Purpose  : Field widths, framing encodings, beat layout and FSM states for
//            the NoC-to-MWC packet arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mgr_noc_mwc_arb_pkg;

    localparam int CNTL_W  = 2;
    localparam int TYPE_W  = 4;
    localparam int PTYPE_W = 4;
    localparam int DATA_W  = 32;
    localparam int MGRID_W = 4;

    localparam logic [CNTL_W-1:0] c_mom     = 2'b00;
    localparam logic [CNTL_W-1:0] c_som     = 2'b01;
    localparam logic [CNTL_W-1:0] c_eom     = 2'b10;
    localparam logic [CNTL_W-1:0] c_som_eom = 2'b11;

    typedef struct packed {
        logic [CNTL_W-1:0]  cntl;
        logic [TYPE_W-1:0]  typ;
        logic [PTYPE_W-1:0] ptype;
        logic [DATA_W-1:0]  data;
        logic               pvalid;
        logic [MGRID_W-1:0] mgr_id;
    } beat_t;

    localparam int BEAT_W = $bits(beat_t);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } arb_state_t;

    function automatic logic is_start(input logic [CNTL_W-1:0] c);
        return (c == c_som) || (c == c_som_eom);
    endfunction

    function automatic logic is_end(input logic [CNTL_W-1:0] c);
        return (c == c_eom) || (c == c_som_eom);
    endfunction

endpackage

`default_nettype wire

// File: rtl/mgr_pkt_fifo.sv
// ============================================================================
// Module   : mgr_pkt_fifo
// Purpose  : Small synchronous FIFO holding one input's packet beats.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mgr_pkt_fifo #(
    parameter int DEPTH   = 4,
    parameter int WIDTH   = 8,
    parameter bit ERR_MSG = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] c_full = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_full;
    logic             w_wr;
    logic             w_rd;

    assign w_full = (r_count == c_full);
    assign empty  = (r_count == '0);
    assign w_wr   = wr_en && !w_full;
    assign w_rd   = rd_en && !empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + (AW+1)'(w_wr) - (AW+1)'(w_rd);
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr_ptr] <= wr_data;
    end

    // A write into a full FIFO means the source ignored ready; the beat is lost.
    always_ff @(posedge clk) begin
        if (ERR_MSG && !rst && wr_en && w_full)
            $error("mgr_pkt_fifo: write to full FIFO, beat dropped");
    end

    assign rd_data = r_mem[r_rd_ptr];
    assign count   = r_count;

endmodule

`default_nettype wire

// File: rtl/mgr_noc_mwc_arb.sv
// ============================================================================
// Module   : mgr_noc_mwc_arb
// Purpose  : Packet-atomic round-robin merge of NoC cp/dp streams into the MWC.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mgr_noc_mwc_arb
    import mgr_noc_mwc_arb_pkg::*;
#(
    parameter int FIFO_DEPTH    = 4,
    parameter int CNT_W         = 16,
    parameter bit FRAME_ERR_MSG = 1'b1
) (
    input  logic               clk,
    input  logic               reset_poweron,
    input  logic               noc__arb__cp_valid,
    input  logic [CNTL_W-1:0]  noc__arb__cp_cntl,
    input  logic [TYPE_W-1:0]  noc__arb__cp_type,
    input  logic [PTYPE_W-1:0] noc__arb__cp_ptype,
    input  logic [DATA_W-1:0]  noc__arb__cp_data,
    input  logic               noc__arb__cp_pvalid,
    input  logic [MGRID_W-1:0] noc__arb__cp_mgrId,
    output logic               arb__noc__cp_ready,
    input  logic               noc__arb__dp_valid,
    input  logic [CNTL_W-1:0]  noc__arb__dp_cntl,
    input  logic [TYPE_W-1:0]  noc__arb__dp_type,
    input  logic [PTYPE_W-1:0] noc__arb__dp_ptype,
    input  logic [DATA_W-1:0]  noc__arb__dp_data,
    input  logic               noc__arb__dp_pvalid,
    input  logic [MGRID_W-1:0] noc__arb__dp_mgrId,
    output logic               arb__noc__dp_ready,
    output logic               arb__mwc__valid,
    output logic [CNTL_W-1:0]  arb__mwc__cntl,
    output logic [TYPE_W-1:0]  arb__mwc__type,
    output logic [PTYPE_W-1:0] arb__mwc__ptype,
    output logic [DATA_W-1:0]  arb__mwc__data,
    output logic               arb__mwc__pvalid,
    output logic [MGRID_W-1:0] arb__mwc__mgrId,
    input  logic               mwc__arb__ready,
    output logic [CNT_W-1:0]   arb__sts__cp_pkts,
    output logic [CNT_W-1:0]   arb__sts__dp_pkts,
    output logic               arb__sts__busy
);

    localparam int CW = $clog2(FIFO_DEPTH);
    // Ready is a cycle late and the source may send once more after it drops.
    localparam logic [CW:0] c_ready_max = (CW+1)'(FIFO_DEPTH-3);

    beat_t      w_cp_in, w_dp_in, w_cp_head, w_dp_head, w_load_beat;
    logic [CW:0] w_cp_count, w_dp_count;
    logic       w_cp_empty, w_dp_empty, w_cp_pop, w_dp_pop;
    logic       w_cp_elig, w_dp_elig, w_cp_bad, w_dp_bad;
    logic       w_xfer, w_stage_free, w_load, w_load_dp;

    arb_state_t       r_state;
    logic             r_lock_dp, r_last_dp, r_cp_ready, r_dp_ready;
    logic             r_out_valid, r_out_dp;
    beat_t            r_out;
    logic [CNT_W-1:0] r_cp_pkts, r_dp_pkts;

    assign w_cp_in = {noc__arb__cp_cntl, noc__arb__cp_type, noc__arb__cp_ptype,
                      noc__arb__cp_data, noc__arb__cp_pvalid, noc__arb__cp_mgrId};
    assign w_dp_in = {noc__arb__dp_cntl, noc__arb__dp_type, noc__arb__dp_ptype,
                      noc__arb__dp_data, noc__arb__dp_pvalid, noc__arb__dp_mgrId};

    mgr_pkt_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(BEAT_W), .ERR_MSG(FRAME_ERR_MSG)) u_cp_fifo (
        .clk(clk), .rst(reset_poweron), .wr_en(noc__arb__cp_valid), .wr_data(w_cp_in),
        .rd_en(w_cp_pop), .rd_data(w_cp_head), .count(w_cp_count), .empty(w_cp_empty)
    );

    mgr_pkt_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(BEAT_W), .ERR_MSG(FRAME_ERR_MSG)) u_dp_fifo (
        .clk(clk), .rst(reset_poweron), .wr_en(noc__arb__dp_valid), .wr_data(w_dp_in),
        .rd_en(w_dp_pop), .rd_data(w_dp_head), .count(w_dp_count), .empty(w_dp_empty)
    );

    assign w_xfer       = r_out_valid && mwc__arb__ready;
    assign w_stage_free = !r_out_valid || w_xfer;
    assign w_cp_elig    = !w_cp_empty && is_start(w_cp_head.cntl);
    assign w_dp_elig    = !w_dp_empty && is_start(w_dp_head.cntl);

    always_comb begin
        w_cp_bad  = 1'b0;
        w_dp_bad  = 1'b0;
        w_load    = 1'b0;
        w_load_dp = 1'b0;
        if (r_state == ST_IDLE) begin
            // Mid-packet heads with no open packet are discarded.
            w_cp_bad = !w_cp_empty && !w_cp_elig;
            w_dp_bad = !w_dp_empty && !w_dp_elig;
            if (w_stage_free && (w_cp_elig || w_dp_elig)) begin
                w_load    = 1'b1;
                w_load_dp = w_dp_elig && (!w_cp_elig || !r_last_dp);
            end
        end else if (w_stage_free) begin
            w_load    = r_lock_dp ? !w_dp_empty : !w_cp_empty;
            w_load_dp = r_lock_dp;
        end
        w_cp_pop    = w_cp_bad || (w_load && !w_load_dp);
        w_dp_pop    = w_dp_bad || (w_load && w_load_dp);
        w_load_beat = w_load_dp ? w_dp_head : w_cp_head;
    end

    always_ff @(posedge clk or posedge reset_poweron) begin
        if (reset_poweron) begin
            r_state     <= ST_IDLE;
            r_lock_dp   <= 1'b0;
            r_last_dp   <= 1'b1;
            r_cp_ready  <= 1'b0;
            r_dp_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_dp    <= 1'b0;
            r_out       <= '0;
            r_cp_pkts   <= '0;
            r_dp_pkts   <= '0;
        end else begin
            r_cp_ready <= (w_cp_count <= c_ready_max);
            r_dp_ready <= (w_dp_count <= c_ready_max);

            if (w_load) begin
                r_out       <= w_load_beat;
                r_out_valid <= 1'b1;
                r_out_dp    <= w_load_dp;
            end else if (w_xfer) begin
                r_out_valid <= 1'b0;
            end

            if (w_xfer && is_end(r_out.cntl)) begin
                if (r_out_dp) r_dp_pkts <= r_dp_pkts + 1'b1;
                else          r_cp_pkts <= r_cp_pkts + 1'b1;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_load) begin
                        r_last_dp <= w_load_dp;
                        r_lock_dp <= w_load_dp;
                        if (!is_end(w_load_beat.cntl)) r_state <= ST_LOCK;
                    end
                end
                ST_LOCK: begin
                    if (w_load && is_end(w_load_beat.cntl)) r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (FRAME_ERR_MSG && !reset_poweron && (w_cp_bad || w_dp_bad))
            $error("mgr_noc_mwc_arb: MOM/EOM head with no open packet, discarded");
    end

    assign arb__noc__cp_ready = r_cp_ready;
    assign arb__noc__dp_ready = r_dp_ready;
    assign arb__mwc__valid    = r_out_valid;
    assign arb__mwc__cntl     = r_out.cntl;
    assign arb__mwc__type     = r_out.typ;
    assign arb__mwc__ptype    = r_out.ptype;
    assign arb__mwc__data     = r_out.data;
    assign arb__mwc__pvalid   = r_out.pvalid;
    assign arb__mwc__mgrId    = r_out.mgr_id;
    assign arb__sts__cp_pkts  = r_cp_pkts;
    assign arb__sts__dp_pkts  = r_dp_pkts;
    assign arb__sts__busy     = (r_state == ST_LOCK);

endmodule

`default_nettype wire

// File: tb/tb_mgr_noc_mwc_arb.sv
// ============================================================================
// Module   : tb_mgr_noc_mwc_arb
// Purpose  : Directed self-checking bench for the cp/dp to MWC arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_mgr_noc_mwc_arb;
    import mgr_noc_mwc_arb_pkg::*;

    logic               clk = 1'b0;
    logic               reset_poweron;
    logic               cp_valid, cp_pvalid, dp_valid, dp_pvalid;
    logic [CNTL_W-1:0]  cp_cntl, dp_cntl;
    logic [TYPE_W-1:0]  cp_type, dp_type;
    logic [PTYPE_W-1:0] cp_ptype, dp_ptype;
    logic [DATA_W-1:0]  cp_data, dp_data;
    logic [MGRID_W-1:0] cp_mgr, dp_mgr;
    logic               cp_ready, dp_ready, mwc_ready;
    logic               out_valid, out_pvalid, busy;
    logic [CNTL_W-1:0]  out_cntl;
    logic [TYPE_W-1:0]  out_type;
    logic [PTYPE_W-1:0] out_ptype;
    logic [DATA_W-1:0]  out_data;
    logic [MGRID_W-1:0] out_mgr;
    logic [15:0]        cp_pkts, dp_pkts;

    always #5 clk = ~clk;

    mgr_noc_mwc_arb #(.FIFO_DEPTH(4), .CNT_W(16), .FRAME_ERR_MSG(1'b0)) dut (
        .clk(clk), .reset_poweron(reset_poweron),
        .noc__arb__cp_valid(cp_valid), .noc__arb__cp_cntl(cp_cntl), .noc__arb__cp_type(cp_type),
        .noc__arb__cp_ptype(cp_ptype), .noc__arb__cp_data(cp_data), .noc__arb__cp_pvalid(cp_pvalid),
        .noc__arb__cp_mgrId(cp_mgr), .arb__noc__cp_ready(cp_ready),
        .noc__arb__dp_valid(dp_valid), .noc__arb__dp_cntl(dp_cntl), .noc__arb__dp_type(dp_type),
        .noc__arb__dp_ptype(dp_ptype), .noc__arb__dp_data(dp_data), .noc__arb__dp_pvalid(dp_pvalid),
        .noc__arb__dp_mgrId(dp_mgr), .arb__noc__dp_ready(dp_ready),
        .arb__mwc__valid(out_valid), .arb__mwc__cntl(out_cntl), .arb__mwc__type(out_type),
        .arb__mwc__ptype(out_ptype), .arb__mwc__data(out_data), .arb__mwc__pvalid(out_pvalid),
        .arb__mwc__mgrId(out_mgr), .mwc__arb__ready(mwc_ready),
        .arb__sts__cp_pkts(cp_pkts), .arb__sts__dp_pkts(dp_pkts), .arb__sts__busy(busy)
    );

    typedef struct {
        logic [DATA_W-1:0]  d;
        logic [CNTL_W-1:0]  c;
        logic [TYPE_W-1:0]  t;
        logic [MGRID_W-1:0] id;
        int                 cyc;
    } rec_t;

    rec_t q[$];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_err = 0;

    always @(posedge clk) cyc++;

    // Beats that will transfer on the next rising edge.
    always @(negedge clk) begin
        if (!reset_poweron && out_valid && mwc_ready)
            q.push_back('{out_data, out_cntl, out_type, out_mgr, cyc});
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic cp_beat(input logic v, input logic [CNTL_W-1:0] c, input logic [DATA_W-1:0] d);
        cp_valid = v; cp_cntl = c; cp_data = d; cp_type = d[3:0]; cp_ptype = ~d[3:0];
        cp_pvalid = v; cp_mgr = 4'h1;
    endtask

    task automatic dp_beat(input logic v, input logic [CNTL_W-1:0] c, input logic [DATA_W-1:0] d);
        dp_valid = v; dp_cntl = c; dp_data = d; dp_type = d[3:0]; dp_ptype = ~d[3:0];
        dp_pvalid = v; dp_mgr = 4'h2;
    endtask

    function automatic logic [CNTL_W-1:0] frame(input int i, input int n);
        if (i == 0)     return c_som;
        if (i == n - 1) return c_eom;
        return c_mom;
    endfunction

    initial begin
        int  k;
        bit  seen_low;
        reset_poweron = 1'b1;
        mwc_ready = 1'b0;
        cp_beat(0, c_mom, 0);
        dp_beat(0, c_mom, 0);
        tick(2);
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_ready", {cp_ready, dp_ready}, 2'b00);
        chk("rst_busy", busy, 0);
        chk("rst_pkts", {cp_pkts, dp_pkts}, 0);
        reset_poweron = 1'b0;
        tick();
        chk("ready_after_rst", {cp_ready, dp_ready}, 2'b11);

        // single cp packet, 2-cycle latency
        mwc_ready = 1'b1;
        q.delete();
        cp_beat(1, c_som, 32'h11); tick();
        chk("t1_lat1_valid", out_valid, 0);
        cp_beat(1, c_mom, 32'h22); tick();
        chk("t1_lat2_valid", out_valid, 1);
        chk("t1_lat2_data", out_data, 32'h11);
        chk("t1_busy_lock", busy, 1);
        cp_beat(1, c_eom, 32'h33); tick();
        cp_beat(0, c_mom, 0); tick(4);
        chk("t1_nbeats", q.size(), 3);
        chk("t1_b0", {q[0].d, q[0].c, q[0].t, q[0].id}, {32'h11, c_som, 4'h1, 4'h1});
        chk("t1_b1", {q[1].d, q[1].c}, {32'h22, c_mom});
        chk("t1_b2", {q[2].d, q[2].c}, {32'h33, c_eom});
        chk("t1_cp_pkts", cp_pkts, 1);
        chk("t1_dp_pkts", dp_pkts, 0);
        chk("t1_busy_idle", busy, 0);

        // simultaneous 4-beat packets: cp wins after reset, no interleave
        reset_poweron = 1'b1; tick();
        reset_poweron = 1'b0; tick();
        q.delete();
        for (int i = 0; i < 4; i++) begin
            cp_beat(1, frame(i, 4), 32'hA0 + i);
            dp_beat(1, frame(i, 4), 32'hB0 + i);
            tick();
        end
        cp_beat(0, c_mom, 0); dp_beat(0, c_mom, 0);
        tick(12);
        chk("t2_nbeats", q.size(), 8);
        for (int i = 0; i < 4; i++) begin
            chk("t2_cp_beat", {q[i].d, q[i].id}, {32'hA0 + i, 4'h1});
            chk("t2_dp_beat", {q[4+i].d, q[4+i].id}, {32'hB0 + i, 4'h2});
        end
        chk("t2_pkts", {cp_pkts, dp_pkts}, {16'd1, 16'd1});

        // alternating single-beat packets at 1 beat/clk
        q.delete();
        for (int i = 0; i < 3; i++) begin
            cp_beat(1, c_som_eom, 32'hC0 + i);
            dp_beat(1, c_som_eom, 32'hD0 + i);
            tick();
        end
        cp_beat(0, c_mom, 0); dp_beat(0, c_mom, 0);
        tick(8);
        chk("t3_nbeats", q.size(), 6);
        for (int i = 0; i < 6; i++)
            chk("t3_order", q[i].d, (i % 2 == 0) ? 32'hC0 + i/2 : 32'hD0 + i/2);
        for (int i = 1; i < 6; i++)
            chk("t3_rate", q[i].cyc - q[i-1].cyc, 1);
        chk("t3_pkts", {cp_pkts, dp_pkts}, {16'd4, 16'd4});

        // MWC stall while dp streams a 6-beat packet obeying ready
        q.delete();
        mwc_ready = 1'b0;
        k = 0;
        seen_low = 0;
        for (int n = 0; n < 24; n++) begin
            if (n == 10) mwc_ready = 1'b1;
            if (!dp_ready) seen_low = 1;
            if (k < 6 && dp_ready) begin
                dp_beat(1, frame(k, 6), 32'hE0 + k);
                k++;
            end else begin
                dp_beat(0, c_mom, 0);
            end
            if (n == 5 || n == 9)
                chk("t4_stall_hold", {out_valid, out_data}, {1'b1, 32'hE0});
            tick();
        end
        dp_beat(0, c_mom, 0);
        tick(6);
        chk("t4_ready_fell", seen_low, 1);
        chk("t4_all_sent", k, 6);
        chk("t4_nbeats", q.size(), 6);
        for (int i = 0; i < 6; i++)
            chk("t4_beat", {q[i].d, q[i].c}, {32'hE0 + i, frame(i, 6)});
        chk("t4_dp_pkts", dp_pkts, 5);

        // orphan EOM in IDLE is dropped, following SOM_EOM forwarded
        q.delete();
        dp_beat(1, c_eom, 32'h5A); tick();
        dp_beat(1, c_som_eom, 32'h5B); tick();
        dp_beat(0, c_mom, 0); tick(5);
        chk("t5_nbeats", q.size(), 1);
        chk("t5_beat", {q[0].d, q[0].c}, {32'h5B, c_som_eom});
        chk("t5_pkts", {cp_pkts, dp_pkts}, {16'd4, 16'd6});

        // asynchronous reset mid-packet
        q.delete();
        cp_beat(1, c_som, 32'h60); tick();
        cp_beat(1, c_mom, 32'h61); tick();
        #2 reset_poweron = 1'b1;
        #1;
        chk("t6_async_valid", out_valid, 0);
        chk("t6_async_data", out_data, 0);
        chk("t6_async_sts", {busy, cp_pkts, dp_pkts}, 0);
        chk("t6_async_ready", {cp_ready, dp_ready}, 2'b00);
        cp_beat(0, c_mom, 0);
        tick(2);
        reset_poweron = 1'b0;
        tick(4);
        chk("t6_flushed", q.size(), 0);
        cp_beat(1, c_som_eom, 32'h70);
        dp_beat(1, c_som_eom, 32'h71);
        tick();
        cp_beat(0, c_mom, 0); dp_beat(0, c_mom, 0);
        tick(5);
        chk("t6_nbeats", q.size(), 2);
        chk("t6_cp_first", {q[0].d, q[0].id}, {32'h70, 4'h1});
        chk("t6_dp_second", {q[1].d, q[1].id}, {32'h71, 4'h2});

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
